id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Scoreboard-based issue controller for the decode stage. Tracks which architectural registers have an in-flight write, raises `stall` toward the fetch/decode pipeline registers on RAW/WAW hazards, and sequences a fixed-length `flush` after a control-flow redirect. It sits beside the decode stage and the register file, consuming decoded register addresses and writeback events, and drives the decode stage's `stall`/`flush` inputs.

## Interface
- `REG_ADDR_W`, 5, register address width
- `NUM_REGS`, 32, architectural registers; must equal 2**REG_ADDR_W
- `FLUSH_CYC`, 2, cycles `flush` is held after a redirect (1..15)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  core enable; 0 blocks issue only
- `id_valid`  in  1  decode stage holds a valid instruction
- `id_rs1`  in  REG_ADDR_W  source register 1 address
- `id_rs2`  in  REG_ADDR_W  source register 2 address
- `id_rd`  in  REG_ADDR_W  destination register address
- `id_reg_wr`  in  1  instruction writes `id_rd`
- `wb_valid`  in  1  writeback retiring this cycle
- `wb_rd`  in  REG_ADDR_W  writeback destination
- `redirect`  in  1  taken branch/jump from execute; one-cycle pulse
- `stall`  out  1  hold fetch/decode pipeline registers
- `flush`  out  1  squash fetch/decode contents
- `issue`  out  1  decode instruction advances this cycle
- `busy_vec`  out  NUM_REGS  pending-write bit per register
- `pending_cnt`  out  REG_ADDR_W+1  population count of `busy_vec`

## Operation
- Scoreboard: `busy_vec` flop array. Bit 0 (x0) is hardwired 0; never set, never causes a hazard.
- Effective busy: `eff[r] = busy_vec[r] & ~(wb_valid & wb_rd==r)` (same-cycle writeback bypass).
- Hazard: `id_valid & (eff[id_rs1] | eff[id_rs2] | (id_reg_wr & eff[id_rd]))`.
- `stall = hazard | ~en` when `id_valid`; 0 when `id_valid`=0. `stall` is forced 0 while `flush`=1.
- `issue = en & id_valid & ~hazard & ~flush & ~redirect`.
- Scoreboard update at posedge: clear `wb_rd` if `wb_valid`; then set `id_rd` if `issue & id_reg_wr & id_rd!=0`. Set wins over clear on the same register.
- Writeback to a non-busy register: ignored, no error.
- Flush FSM states: IDLE, FLUSH. 4-bit down-counter `fcnt`.
  - IDLE + `redirect` -> FLUSH, `fcnt=FLUSH_CYC-1`.
  - FLUSH: `fcnt==0` and no `redirect` -> IDLE; otherwise `fcnt` decrements.
  - FLUSH + `redirect` -> restart, `fcnt=FLUSH_CYC-1`.
- Scoreboard writebacks and FSM advance regardless of `en`.
- `pending_cnt` is registered; it equals popcount of the `busy_vec` value presented in the same cycle.

## Timing
- Reset (async assert, sync-released by the clock domain): `busy_vec`=0, `pending_cnt`=0, FSM=IDLE, `fcnt`=0, `flush`=0. `stall`/`issue` are combinational; both 0 with `id_valid`=0.
- `stall`, `issue` are combinational from current-cycle inputs and registered state; zero-latency.
- `flush` is registered: asserts the cycle after `redirect`, held exactly `FLUSH_CYC` cycles; back-to-back redirects extend it.
- A register becomes busy the cycle after issue; a dependent instruction in the next cycle stalls.
- A writeback clears the hazard in the same cycle (bypass); the busy bit drops the next cycle.
- Reset mid-flush or with busy registers: all state cleared immediately, no partial flush afterward.

## Test plan
- Reset with `id_valid`=1, rs1=rs2=rd=3 -> `stall`=0, `issue`=1, `busy_vec`=0 during reset, `pending_cnt`=0.
- Issue rd=5 write; next cycle rs1=5 -> `stall`=1, `issue`=0; assert `wb_valid`, `wb_rd`=5 -> `stall`=0, `issue`=1 the same cycle, `busy_vec[5]`=0 the following cycle.
- Issue rd=0 write, then rs1=0 -> `busy_vec`=0, no stall ever.
- `wb_rd`=7 and issue with rd=7 in the same cycle -> `busy_vec[7]`=1 next cycle, `pending_cnt`=1.
- `redirect` pulse with FLUSH_CYC=2 -> `flush`=1 for cycles +1 and +2, `issue`=0 throughout; second `redirect` at +1 -> `flush` high through +3.
- Fill registers 1..31 busy -> `pending_cnt`=31; `rst_n` low mid-sequence -> `busy_vec`=0, `flush`=0 asynchronously.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: register scoreboard for RAW/WAW stalls plus
// a fixed-length flush sequencer after a control-flow redirect.
module id_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int FLUSH_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_wr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  flush,
    output logic                  issue,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [REG_ADDR_W:0]   pending_cnt
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                state, state_next;
    logic [3:0]            fcnt, fcnt_next;
    logic [NUM_REGS-1:0]   eff_busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  hazard;

    function automatic logic [REG_ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [REG_ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + (REG_ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // A retiring writeback releases its register in the same cycle it lands.
    always_comb begin
        eff_busy = busy_vec;
        if (wb_valid) begin
            eff_busy[wb_rd] = 1'b0;
        end
    end

    assign hazard = id_valid & (eff_busy[id_rs1] | eff_busy[id_rs2] |
                                (id_reg_wr & eff_busy[id_rd]));
    assign flush  = (state == FLUSH);
    assign stall  = id_valid & ~flush & (hazard | ~en);
    assign issue  = en & id_valid & ~hazard & ~flush & ~redirect;

    // Set is applied after clear so a re-issue to a retiring register stays busy.
    always_comb begin
        busy_next = busy_vec;
        if (wb_valid) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (issue && id_reg_wr && (id_rd != '0)) begin
            busy_next[id_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_next = FLUSH;
                    fcnt_next  = 4'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (redirect) begin
                    fcnt_next = 4'(FLUSH_CYC - 1);
                end else if (fcnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    fcnt_next = fcnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                fcnt_next  = 4'd0;
            end
        endcase
    end

    // pending_cnt is computed from busy_next so it lines up with busy_vec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec    <= '0;
            pending_cnt <= '0;
            state       <= IDLE;
            fcnt        <= 4'd0;
        end else begin
            busy_vec    <= busy_next;
            pending_cnt <= popcount(busy_next);
            state       <= state_next;
            fcnt        <= fcnt_next;
        end
    end

endmodule
